spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first, single chip select, programmable sclk
// half-period (CLK_DIV), word width (DATA_W) and minimum cs-high gap (CS_GAP).
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE, GAP} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIT_W-1:0]    r_bit;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;

    logic                w_div_end;
    logic                w_gap_end;
    logic                w_last_bit;
    logic                w_accept;
    logic [DATA_W-1:0]   w_tx_shift;
    logic [DATA_W-1:0]   w_rx_shift;

    assign w_div_end  = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_gap_end  = (r_cnt == CNT_W'(CS_GAP - 1));
    assign w_last_bit = (r_bit == BIT_W'(DATA_W - 1));
    assign w_tx_shift = r_tx << 1;
    assign w_rx_shift = (r_rx << 1) | DATA_W'(miso);
    // A start present as the gap expires is taken on that same edge, so a
    // held start gives a cs-high window of exactly DONE + CS_GAP cycles.
    assign w_accept   = start && ((r_state == IDLE) || (r_state == GAP && w_gap_end));

    // Transfer sequencer: state, counters, shift registers and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_state <= SETUP;
                r_cnt   <= '0;
                r_bit   <= '0;
                r_tx    <= tx_data;
                r_rx    <= '0;
                cs      <= 1'b0;
                busy    <= 1'b1;
                sclk    <= 1'b0;
                mosi    <= tx_data[DATA_W-1];
            end else begin
                case (r_state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    SETUP: begin
                        if (w_div_end) begin
                            r_cnt   <= '0;
                            r_state <= HIGH;
                            sclk    <= 1'b1;
                            r_rx    <= w_rx_shift;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (w_div_end) begin
                            r_cnt   <= '0;
                            r_state <= LOW;
                            sclk    <= 1'b0;
                            // mosi only moves on the falling edge; after the
                            // final bit it simply holds.
                            if (!w_last_bit) begin
                                r_tx <= w_tx_shift;
                                mosi <= w_tx_shift[DATA_W-1];
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    LOW: begin
                        if (w_div_end) begin
                            r_cnt <= '0;
                            if (w_last_bit) begin
                                r_state <= DONE;
                                r_bit   <= '0;
                                cs      <= 1'b1;
                                done    <= 1'b1;
                                mosi    <= 1'b0;
                                rx_data <= r_rx;
                            end else begin
                                r_bit   <= r_bit + BIT_W'(1);
                                r_state <= HIGH;
                                sclk    <= 1'b1;
                                r_rx    <= w_rx_shift;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    DONE: begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                    end
                    GAP: begin
                        if (w_gap_end) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        cs      <= 1'b1;
                        sclk    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
